// File: rtl/calc_pkg.sv
// Shared calculator-datapath definitions used by the keypad front end.
package calc_pkg;

    localparam int KP_ROWS   = 4;
    localparam int KP_COLS   = 4;
    localparam int KP_IDX_W  = 2;
    localparam int KP_CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD,
        RELEASE
    } kp_state_t;

    // Lowest-index asserted column wins so multi-key presses resolve deterministically.
    function automatic logic [KP_IDX_W-1:0] lowest_col(input logic [KP_COLS-1:0] cols);
        lowest_col = '0;
        for (int i = KP_COLS - 1; i >= 0; i--) begin
            if (cols[i]) lowest_col = i[KP_IDX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer of parameterized width for asynchronous level inputs.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// Press-aware 4x4 keypad scanner with debounce; optional auto-repeat while held
// is enabled by defining KEYPAD_SCAN_REPEAT_EN.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1024
`ifdef KEYPAD_SCAN_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 2**20
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KP_COLS-1:0]   col_in,
    output logic [KP_ROWS-1:0]   row_out,
    output logic [KP_IDX_W-1:0]  row_idx,
    output logic [KP_CODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 key_held
);

    localparam int DW_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_CNT);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_ACC  = DB_W'(DEBOUNCE_CNT - 1);
    // The HOLD cycle that first sees the column low counts toward the release run.
    localparam logic [DB_W-1:0] DB_REL  = DB_W'(DEBOUNCE_CNT - 2);

    logic [KP_COLS-1:0] col_s;

    sync2 #(.WIDTH(KP_COLS)) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_in),
        .q     (col_s)
    );

    kp_state_t               state_q, state_d;
    logic [DW_W-1:0]         dw_q, dw_d;
    logic [DB_W-1:0]         db_q, db_d;
    logic [KP_IDX_W-1:0]     row_q, row_d;
    logic [KP_IDX_W-1:0]     col_q, col_d;
    logic [KP_CODE_W-1:0]    code_q, code_d;
    logic                    valid_q, valid_d;
    logic                    held_q, held_d;
    logic                    col_hit;

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int RC_W = $clog2(REPEAT_CYCLES);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REPEAT_CYCLES - 1);
    logic [RC_W-1:0] rc_q, rc_d;
`endif

    assign col_hit = col_s[col_q];

    always_comb begin
        state_d = state_q;
        dw_d    = dw_q;
        db_d    = db_q;
        row_d   = row_q;
        col_d   = col_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_SCAN_REPEAT_EN
        rc_d    = '0;
`endif
        case (state_q)
            SCAN: begin
                if (dw_q == DW_LAST) begin
                    dw_d = '0;
                    if (|col_s) begin
                        col_d   = lowest_col(col_s);
                        db_d    = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    dw_d = dw_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!col_hit) begin
                    state_d = SCAN;
                    row_d   = row_q + 1'b1;
                    dw_d    = '0;
                end else if (db_q == DB_ACC) begin
                    code_d  = {row_q, col_q};
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HOLD: begin
                if (!col_hit) begin
                    state_d = RELEASE;
                    db_d    = '0;
                end
`ifdef KEYPAD_SCAN_REPEAT_EN
                else if (rc_q == RC_LAST) begin
                    valid_d = 1'b1;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (col_hit) begin
                    state_d = HOLD;
                end else if (db_q == DB_REL) begin
                    state_d = SCAN;
                    held_d  = 1'b0;
                    row_d   = row_q + 1'b1;
                    dw_d    = '0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
            dw_q    <= '0;
            db_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dw_q    <= dw_d;
            db_q    <= db_d;
            row_q   <= row_d;
            col_q   <= col_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

`ifdef KEYPAD_SCAN_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) rc_q <= '0;
        else       rc_q <= rc_d;
    end
`endif

    assign row_out   = {{(KP_ROWS-1){1'b0}}, 1'b1} << row_q;
    assign row_idx   = row_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: run-length reference model plus literal timing checks.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int RC = 16;
`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_in = 4'b0;
    logic [3:0] row_out;
    logic [1:0] row_idx;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    keypad_scan #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
`ifdef KEYPAD_SCAN_REPEAT_EN
        , .REPEAT_CYCLES(RC)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .row_idx   (row_idx),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: run lengths of the synchronized column, no state encoding.
    int         e_row = 0, e_code = 0, tick = 0, run = 0, lo = 0, rep = 0, m_col = 0;
    bit         e_valid = 0, e_held = 0, locked = 0, pressed = 0;
    logic [3:0] mp0 = 0, mp1 = 0, cs;

    initial begin
        forever begin
            @(posedge clk);
            cs  = mp1;
            mp1 = mp0;
            mp0 = col_in;
            if (reset) begin
                mp0 = 0; mp1 = 0; e_row = 0; e_code = 0; e_valid = 0; e_held = 0;
                tick = 0; run = 0; lo = 0; rep = 0; locked = 0; pressed = 0;
            end else begin
                e_valid = 0;
                if (!locked) begin
                    if (tick == SD - 1) begin
                        tick = 0;
                        if (cs != 0) begin
                            locked = 1; pressed = 0; run = 0;
                            for (int i = 3; i >= 0; i--) if (cs[i]) m_col = i;
                        end else e_row = (e_row + 1) % 4;
                    end else tick++;
                end else if (!pressed) begin
                    if (!cs[m_col]) begin
                        locked = 0; e_row = (e_row + 1) % 4;
                    end else begin
                        run++;
                        if (run == DC) begin
                            pressed = 1; lo = 0; rep = 0;
                            e_valid = 1; e_held = 1; e_code = e_row * 4 + m_col;
                        end
                    end
                end else if (cs[m_col]) begin
                    if (lo > 0) begin
                        lo = 0; rep = 0;
                    end else if (REP_ON) begin
                        rep++;
                        if (rep == RC) begin rep = 0; e_valid = 1; end
                    end
                end else begin
                    lo++; rep = 0;
                    if (lo == DC) begin
                        locked = 0; pressed = 0; e_held = 0; tick = 0;
                        e_row = (e_row + 1) % 4;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_row_idx",   32'(row_idx),   32'(e_row));
                chk("m_row_out",   32'(row_out),   32'(1 << e_row));
                chk("m_key_code",  32'(key_code),  32'(e_code));
                chk("m_key_valid", 32'(key_valid), 32'(e_valid));
                chk("m_key_held",  32'(key_held),  32'(e_held));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the first negedge on which the requested row is driven.
    task automatic wait_row(input logic [3:0] r);
        int n = 0;
        while (row_out !== r && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_row_timeout", 32'(row_out), 32'(r));
    endtask

    task automatic press(input logic [3:0] cols, output int lat);
        col_in = cols;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_key(output int lat);
        col_in = 4'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!key_held) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic idle(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
    endtask

    initial begin
        int lat, pulses, first, last;

        // 1: reset and idle scan
        do_reset();
        chk_en = 1'b1;
        chk("rst_row_out", 32'(row_out), 32'h1);
        chk("rst_row_idx", 32'(row_idx), 32'h0);
        chk("rst_key_code", 32'(key_code), 32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_held", 32'(key_held), 32'h0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            chk("idle_row_out", 32'(row_out), 32'(1 << ((k / 4) % 4)));
            if (key_valid) pulses++;
            @(negedge clk);
        end
        chk("idle_pulses", 32'(pulses), 32'h0);

        // 2: clean press of row 2 col 2
        wait_row(4'b0100);
        press(4'b0100, lat);
        chk("press_a_lat", 32'(lat), 32'd12);
        chk("press_a_code", 32'(key_code), 32'hA);
        chk("press_a_held", 32'(key_held), 32'h1);
        idle(10, pulses);
        chk("press_a_single", 32'(pulses), 32'h0);
        chk("press_a_frozen", 32'(row_out), 32'b0100);

        // 4: release glitch then final release
        col_in = 4'b0;
        idle(4, pulses);
        col_in = 4'b0100;
        idle(12, pulses);
        chk("glitch_no_strobe", 32'(pulses), 32'h0);
        chk("glitch_held", 32'(key_held), 32'h1);
        release_key(lat);
        chk("release_lat", 32'(lat), 32'd10);
        chk("release_row_idx", 32'(row_idx), 32'd3);
        chk("release_code_kept", 32'(key_code), 32'hA);

        // 3: bounce reject on row 1 col 1
        wait_row(4'b0010);
        col_in = 4'b0010;
        idle(5, pulses);
        col_in = 4'b0;
        idle(3, first);
        chk("bounce_no_strobe", 32'(pulses + first), 32'h0);
        chk("bounce_resume_row", 32'(row_out), 32'b0100);

        // 5: multi-key resolves to lowest column; reset during debounce
        wait_row(4'b1000);
        press(4'b1001, lat);
        chk("multi_lat", 32'(lat), 32'd12);
        chk("multi_code", 32'(key_code), 32'hC);
        release_key(lat);
        chk("multi_release_lat", 32'(lat), 32'd10);
        wait_row(4'b0001);
        col_in = 4'b0001;
        idle(6, pulses);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_row_out", 32'(row_out), 32'h1);
        chk("midrst_key_code", 32'(key_code), 32'h0);
        chk("midrst_key_valid", 32'(key_valid), 32'h0);
        chk("midrst_key_held", 32'(key_held), 32'h0);
        reset = 1'b0;
        col_in = 4'b0;
        idle(20, first);
        chk("midrst_no_strobe", 32'(pulses + first), 32'h0);

        // 6: hold key 5 for 60 cycles after acceptance
        do_reset();
        wait_row(4'b0010);
        press(4'b0010, lat);
        chk("rep_press_lat", 32'(lat), 32'd12);
        chk("rep_press_code", 32'(key_code), 32'h5);
        pulses = 0; first = -1; last = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                chk("rep_code", 32'(key_code), 32'h5);
                if (first < 0) first = i;
                else chk("rep_spacing", 32'(i - last), 32'd16);
                last = i;
            end
        end
        chk("rep_pulses", 32'(pulses), REP_ON ? 32'd3 : 32'd0);
        if (REP_ON) chk("rep_first", 32'(first), 32'd16);
        release_key(lat);
        chk("rep_release_lat", 32'(lat), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end for the calculator datapath. It drives one of four keypad rows at a time and samples the four column lines. A pressed key is debounced and reported as a 4-bit raw key index with a one-cycle valid strobe. The outputs feed the keypad encoder's `keyboard`/`counter` inputs and the register-bank write enable `EN`. This block replaces the free-running 2-bit counter with a press-aware scanner.

## Interface
- `SCAN_DIV`, default 16: clock cycles each row is driven, minimum 3.
- `DEBOUNCE_CNT`, default 1024: consecutive stable cycles required for a press or a release, minimum 2.
- `REPEAT_CYCLES`, default 2^20: auto-repeat period. Used only when `KEYPAD_SCAN_REPEAT_EN` is defined.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `col_in` in 4: raw keypad columns, active-high, asynchronous to `clk`.
- `row_out` out 4: one-hot row drive, active-high.
- `row_idx` out 2: binary index of the driven row. Goes to the encoder's `counter` input.
- `key_code` out 4: last accepted key, `{row, col}`, so row*4+col.
- `key_valid` out 1: one-cycle strobe when a key is accepted. Goes to the register-bank `EN`.
- `key_held` out 1: high while an accepted key remains pressed.

## Operation
- `col_in` passes through a 2-flop synchronizer, giving `col_s`. All decisions use `col_s`.
- State machine: SCAN, DEBOUNCE, HOLD, RELEASE. Reset state is SCAN.
- **SCAN**
  - Dwell counter `dw` runs 0..SCAN_DIV-1.
  - When `dw`==SCAN_DIV-1, `col_s` is sampled.
    - If no column is high: `row_idx` increments mod 4 (3 wraps to 0) and `dw` returns to 0.
    - If any column is high: the lowest-index high column is latched as `col_q` and the machine goes to DEBOUNCE with `db`=0. Lowest index wins, so a multi-key press resolves deterministically.
- **DEBOUNCE**
  - The row is frozen.
  - Each cycle with `col_s[col_q]`=1 increments `db`.
  - Any cycle with `col_s[col_q]`=0 returns to SCAN with `row_idx`+1 and `dw`=0. This is a bounce reject with no output.
  - When `db` reaches DEBOUNCE_CNT-1 with the column still high, the next cycle does three things: `key_code`<={row_idx,col_q}, `key_valid`=1, state goes to HOLD.
- **HOLD**
  - The row stays frozen and `key_held`=1.
  - On `col_s[col_q]`=0, go to RELEASE with `db`=0.
- **RELEASE**
  - Each cycle with `col_s[col_q]`=0 increments `db`.
  - If the column returns high, go back to HOLD. That press does not produce a new strobe.
  - At DEBOUNCE_CNT consecutive low cycles: go to SCAN, `key_held`=0, `row_idx`+1, `dw`=0.
- `key_code` holds its value until the next accepted key. Other keys pressed during HOLD or RELEASE are ignored.
- `row_out` = 1<<`row_idx` at all times.

## Timing
- Reset values:
  - `row_out`=4'b0001, `row_idx`=0
  - `key_code`=0, `key_valid`=0, `key_held`=0
  - `dw`=0, `db`=0, synchronizer flops 0
- Reset asserted mid-operation (any state) forces all of the above on the next edge and drops any pending strobe.
- Input to sample: 2 cycles of synchronizer latency. A `col_in` change lands in `col_s` 2 edges later, and SCAN_DIV≥3 guarantees the sampled row is settled.
- Press latency: sample edge S, then DEBOUNCE entered at S+1. `key_valid` is high during cycle S+DEBOUNCE_CNT+1 for exactly one cycle, with `key_code` valid in that same cycle and stable after it.
- Minimum spacing between two `key_valid` strobes without auto-repeat: 2*DEBOUNCE_CNT+3 cycles.
- `key_held` rises together with `key_valid`. It falls on the same edge that RELEASE exits to SCAN.
- All outputs are registered. There is no combinational path from `col_in` to any output.

## Configuration
- Macro: `KEYPAD_SCAN_REPEAT_EN`.
- **Defined:** in HOLD, a repeat counter starts at 0 on entry.
  - Every REPEAT_CYCLES cycles it re-asserts `key_valid` for one cycle, with `key_code` unchanged.
  - The counter clears on exit from HOLD.
  - Counting pauses in RELEASE and restarts from 0 on re-entry to HOLD.
- **Undefined:** exactly one `key_valid` per accepted press. The repeat counter and the REPEAT_CYCLES logic are not synthesized.

## Structure
- Shared package `calc_pkg` holds:
  - the state enum `kp_state_t` (SCAN, DEBOUNCE, HOLD, RELEASE)
  - `KP_ROWS`=4, `KP_COLS`=4
  - the key-code width constant 4
- One sub-module: `sync2`, a parameterized-width two-flop synchronizer, instantiated at width 4 on `col_in`.
- Counter widths are `$clog2` of their parameters.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8.

1. **Reset and idle.** Assert `reset` for 2 cycles, then keep `col_in`=0 for 40 cycles. Required: `row_out` cycles 0001→0010→0100→1000→0001 every 4 cycles, and `key_valid` never asserts.
2. **Clean press.** Hold `col_in`=4'b0100 while row 2 is driven. Required: one `key_valid` pulse with `key_code`=4'hA, the pulse 9 cycles after the sample edge. `key_held`=1 and `row_out` frozen at 0100 until release.
3. **Bounce reject.** Raise col 1 on row 1 for 5 cycles, then drop it. Required: no `key_valid`, and scanning resumes at row 2.
4. **Release glitch.** After case 2, drop col 2 for 4 cycles, raise it again, then hold. Required: `key_held` stays 1 and no second `key_valid`. After a final release of 8 cycles, `key_held`=0 and `row_idx`=3.
5. **Multi-key and mid-operation reset.** Raise cols 0 and 3 together on row 3. Required: `key_code`=4'hC. Assert `reset` in DEBOUNCE on a second press. Required: all outputs return to reset values on the next edge and no strobe is produced.
6. **Auto-repeat.** With `KEYPAD_SCAN_REPEAT_EN` and REPEAT_CYCLES=16, hold key 5 for 60 cycles after acceptance. Required: 3 additional `key_valid` pulses spaced 16 cycles apart, each with `key_code`=4'h5.
